// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit single-cycle CPU front end.
package cpu_pkg;

  localparam int unsigned DEF_PC_W     = 32;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam int unsigned DEF_OFFSET_W = 8;
  localparam int unsigned INSTR_BYTES  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC computation: sequential step or taken jump/BEQ target.
// Offsets count instructions, so they are scaled to bytes before the add.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned OFFSET_W = DEF_OFFSET_W
) (
  input  logic [PC_W-1:0]     pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                jump,
  input  logic                branch,
  input  logic                zero,
  output logic [PC_W-1:0]     pc_plus4,
  output logic [PC_W-1:0]     next_pc
);

  localparam int unsigned ShAmt = $clog2(INSTR_BYTES);

  logic [PC_W-1:0] offset_ext;

  // Sign-extend the offset and pick the fall-through or taken target; wraps mod 2^PC_W.
  always_comb begin
    offset_ext = PC_W'($signed(offset));
    pc_plus4   = pc + PC_W'(INSTR_BYTES);
    next_pc    = pc_plus4;
    if (jump || (branch && zero)) begin
      next_pc = pc_plus4 + (offset_ext << ShAmt);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory with a
// req/valid handshake and hands each word to the decoder with valid/ready.
// Optional build macro FETCH_COUNT_EN adds a saturating retired_count output.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W     = DEF_PC_W,
  parameter int unsigned      INSTR_W  = DEF_INSTR_W,
  parameter int unsigned      OFFSET_W = DEF_OFFSET_W,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(DEF_RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_valid,
  input  logic [INSTR_W-1:0]  imem_instr,
  output logic [INSTR_W-1:0]  instr,
  output logic                instr_valid,
  input  logic                instr_ready,
  input  logic                jump,
  input  logic                branch,
  input  logic                zero,
  input  logic [OFFSET_W-1:0] offset,
  output logic [PC_W-1:0]     pc,
`ifdef FETCH_COUNT_EN
  output logic [15:0]         retired_count,
`endif
  output logic [PC_W-1:0]     pc_plus4
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               imem_req_q;
  logic               instr_valid_q;
  logic               issue_fire;
  logic [PC_W-1:0]    next_pc;

  pc_next_calc #(
    .PC_W     (PC_W),
    .OFFSET_W (OFFSET_W)
  ) u_pc_next_calc (
    .pc       (pc_q),
    .offset   (offset),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // Next-state logic: advance the PC only when the decoder takes the instruction.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    issue_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_valid) begin
          instr_d = imem_instr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          issue_fire = 1'b1;
          pc_d       = next_pc;
          state_d    = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; handshake flags are precomputed from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      imem_req_q    <= (state_d == FETCH);
      instr_valid_q <= (state_d == ISSUE);
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] retired_q;

  // Count accepted instructions, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (issue_fire && (retired_q != 16'hFFFF)) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_count = retired_q;
`endif

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a scoreboard of fetched words and a
// reference next-PC model. Covers FETCH_COUNT_EN when that macro is defined.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_instr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [7:0]  offset;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
`ifdef FETCH_COUNT_EN
  logic [15:0] retired_count;
  logic [15:0] d2_retired_count;
`endif

  // Second instance parked near the top of the address space for wrap checks.
  logic        d2_imem_req;
  logic [31:0] d2_imem_addr;
  logic [31:0] d2_instr;
  logic        d2_instr_valid;
  logic [31:0] d2_pc;
  logic [31:0] d2_pc_plus4;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_pc;
  logic [31:0] sb[$];
  logic        hs_seen;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_instr    (imem_instr),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .jump          (jump),
    .branch        (branch),
    .zero          (zero),
    .offset        (offset),
    .pc            (pc),
`ifdef FETCH_COUNT_EN
    .retired_count (retired_count),
`endif
    .pc_plus4      (pc_plus4)
  );

  pc_fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut2 (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (d2_imem_req),
    .imem_addr     (d2_imem_addr),
    .imem_valid    (1'b1),
    .imem_instr    (32'h0000_0000),
    .instr         (d2_instr),
    .instr_valid   (d2_instr_valid),
    .instr_ready   (1'b1),
    .jump          (1'b0),
    .branch        (1'b0),
    .zero          (1'b0),
    .offset        (8'h00),
    .pc            (d2_pc),
`ifdef FETCH_COUNT_EN
    .retired_count (d2_retired_count),
`endif
    .pc_plus4      (d2_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory answers only while requested; otherwise drives junk to catch stray captures.
  assign imem_instr = imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  function automatic logic [31:0] model_next(input logic [31:0] p, input logic j, input logic b,
                                             input logic z, input logic [7:0] off);
    logic [31:0] disp;
    disp = {{22{off[7]}}, off, 2'b00};
    if (j || (b && z)) return p + 32'd4 + disp;
    return p + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  // One clock: scoreboard bookkeeping at the negedge, return just after the posedge.
  task automatic cycle();
    logic [31:0] w;
    @(negedge clk);
    hs_seen = 1'b0;
    if (!reset) begin
      if (imem_req && imem_valid) begin
        chk("fetch_addr", imem_addr, exp_pc);
        sb.push_back(mem_word(exp_pc));
      end
      if (instr_valid && instr_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL sb_empty: observed=issue expected=no_issue");
        end else begin
          w = sb.pop_front();
          chk("issue_instr", instr, w);
          chk("issue_pc", pc, exp_pc);
          chk("issue_pc_plus4", pc_plus4, exp_pc + 32'd4);
          exp_pc  = model_next(exp_pc, jump, branch, zero, offset);
          hs_seen = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Fetch and retire one instruction with zero-latency memory, starting in FETCH.
  task automatic run_instr(input logic j, input logic b, input logic z, input logic [7:0] off,
                           input logic [31:0] want, input string tag);
    int n;
    jump        = j;
    branch      = b;
    zero        = z;
    offset      = off;
    imem_valid  = 1'b1;
    instr_ready = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!hs_seen && n < 8);
    chk({tag, "_cycles"}, n, 2);
    chk({tag, "_pc"}, pc, want);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    hs_seen     = 1'b0;
    exp_pc      = 32'h0;
    reset       = 1'b1;
    imem_valid  = 1'b0;
    instr_ready = 1'b0;
    jump        = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    offset      = 8'h00;

    // Reset held for two edges.
    cycle();
    cycle();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_d2_pc", d2_pc, 32'hFFFF_FFFC);
    reset = 1'b0;
    chk("rst_state_idle", dut.state_q, 32'(cpu_pkg::IDLE));
`ifdef FETCH_COUNT_EN
    chk("rst_count", retired_count, 0);
`endif

    // IDLE -> FETCH.
    imem_valid  = 1'b1;
    instr_ready = 1'b1;
    cycle();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", instr_valid, 0);

    // FETCH -> ISSUE on both instances; d2 sits at the top address.
    cycle();
    chk("d2_issue_valid", d2_instr_valid, 1);
    chk("d2_pc_top", d2_pc, 32'hFFFF_FFFC);
    chk("d2_addr_top", d2_imem_addr, 32'hFFFF_FFFC);
    chk("d2_plus4_wrap", d2_pc_plus4, 32'h0);
    chk("d2_instr", d2_instr, 32'h0);

    // Handshake on both: main goes 0 -> 4, d2 wraps to 0.
    cycle();
    chk("seq_pc_4", pc, 32'h4);
    chk("d2_wrap_pc", d2_pc, 32'h0);
    chk("d2_req_after_wrap", d2_imem_req, 1);

    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h08, "seq8");
    run_instr(1'b0, 1'b0, 1'b1, 8'h7F, 32'h0C, "seq12");
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h10, "seq16");

    // Memory stall in FETCH at pc 0x10.
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fstall_req", imem_req, 1);
      chk("fstall_pc", pc, 32'h10);
      chk("fstall_valid", instr_valid, 0);
    end
    imem_valid  = 1'b1;
    instr_ready = 1'b0;
    cycle();
    // Decoder stall in ISSUE; imem_valid stays high and must be ignored.
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("istall_valid", instr_valid, 1);
      chk("istall_instr", instr, mem_word(32'h10));
      chk("istall_pc", pc, 32'h10);
      chk("istall_req", imem_req, 0);
    end
    jump        = 1'b1;
    offset      = 8'hFE;
    instr_ready = 1'b1;
    cycle();
    chk("jump_back_pc", pc, 32'h0C);

    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h10, "seq_to_10");
    run_instr(1'b0, 1'b1, 1'b0, 8'h03, 32'h14, "beq_not_taken");
    run_instr(1'b1, 1'b0, 1'b0, 8'hFE, 32'h10, "jump_m2");
    run_instr(1'b0, 1'b1, 1'b1, 8'h03, 32'h20, "beq_taken");
    run_instr(1'b1, 1'b0, 1'b0, 8'hFF, 32'h20, "jump_self");
    run_instr(1'b1, 1'b1, 1'b0, 8'h02, 32'h2C, "jump_and_beq");

    // Reset while ISSUE is ready to fire: nothing retires.
    instr_ready = 1'b0;
    cycle();
    chk("pre_rst_valid", instr_valid, 1);
    reset       = 1'b1;
    instr_ready = 1'b1;
    jump        = 1'b1;
    offset      = 8'h05;
    cycle();
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_req", imem_req, 0);
    chk("midrst_instr", instr, 32'h0);
    reset = 1'b0;
    sb.delete();
    exp_pc = 32'h0;
    cycle();
    chk("post_rst_req", imem_req, 1);

`ifdef FETCH_COUNT_EN
    chk("cnt_after_rst", retired_count, 0);
    for (int i = 0; i < 5; i++) begin
      run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'(4 * (i + 1)), "cnt_seq");
    end
    chk("cnt_five", retired_count, 5);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    run_instr(1'b0, 1'b0, 1'b0, 8'h00, 32'h18, "cnt_sat_seq");
    chk("cnt_saturate", retired_count, 32'hFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of the system clock generator in the 8-bit single-cycle CPU.
- Holds the program counter and fetches each instruction from instruction memory with a req/valid handshake.
- Presents each fetched instruction to the decoder with a valid/ready handshake.
- Computes the next PC from the decoder's jump/branch outcome: sequential, jump, or taken BEQ.

Parameters:
PC_W, 32, program counter width in bits (byte address)
INSTR_W, 32, instruction word width
OFFSET_W, 8, signed jump/branch offset width, counted in instructions
RESET_PC, 0, PC value loaded at reset

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  PC_W  fetch address; always equals pc
imem_valid  in  1  instruction memory has returned imem_instr this cycle
imem_instr  in  INSTR_W  returned instruction word
instr  out  INSTR_W  instruction presented to the decoder
instr_valid  out  1  instr is valid
instr_ready  in  1  decoder/datapath accepts instr this cycle (low = stall, e.g. data-memory busywait)
jump  in  1  decoded J for the current instr
branch  in  1  decoded BEQ for the current instr
zero  in  1  ALU zero flag for the current instr
offset  in  OFFSET_W  signed offset for the current instr, in instructions
pc  out  PC_W  PC of the current instr
pc_plus4  out  PC_W  pc + 4, modulo 2^PC_W

Behaviour:
- Reset values (at the clock edge with reset=1):
  - state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0.
  - Reset wins over every other input.
- Reset mid-fetch or mid-issue: the in-flight instruction is discarded. imem_req and instr_valid are low in the cycle after the reset edge.
- State machine:
  - IDLE: imem_req=0, instr_valid=0. Always goes to FETCH on the next edge.
  - FETCH: imem_req=1, imem_addr=pc. When imem_valid=1: instr <= imem_instr, go to ISSUE. Otherwise stay in FETCH; wait is unbounded.
  - ISSUE: instr_valid=1, imem_req=0. Handshake fires when instr_valid && instr_ready.
    - On the handshake, pc <= next_pc and the FSM goes to FETCH.
    - Without the handshake, instr, pc and state hold.
- jump, branch, zero and offset are sampled only on the ISSUE handshake edge; they are don't-care at all other times.
- imem_valid is ignored outside FETCH.
- imem_instr is captured only on FETCH && imem_valid.
- next_pc:
  - Taken (jump=1, or branch=1 && zero=1): pc + 4 + (sign_extend(offset) << 2).
  - Otherwise: pc + 4.
  - jump=1 and branch=1 together: treated as taken.
- Arithmetic is unsigned modulo 2^PC_W with silent wrap:
  - pc=0xFFFFFFFC not taken -> 0x00000000.
  - offset=0xFF (-1) gives target = pc.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle imem_valid, then ISSUE with ready=1).
- Outputs are registered, except imem_addr (= pc) and pc_plus4 (combinational from pc).

Optional Feature:
- Macro: FETCH_COUNT_EN.
- Defined:
  - Adds output retired_count [15:0], reset 0.
  - Increments by 1 on each ISSUE handshake.
  - Saturates at 0xFFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum {IDLE, FETCH, ISSUE};
  - PC_W, INSTR_W, OFFSET_W defaults;
  - INSTR_BYTES=4;
  - RESET_PC default.
- One combinational sub-module, pc_next_calc: inputs pc, offset, jump, branch, zero; outputs pc_plus4 and next_pc.
- The FSM and registers stay in pc_fetch_unit.

Test Plan:
1. Reset check: hold reset 2 cycles -> pc=0, imem_req=0, instr_valid=0. The cycle after release, state is IDLE; the next cycle imem_req=1 with imem_addr=0.
2. Sequential fetch, zero-latency memory: imem_valid=1 every FETCH, instr_ready=1, no jump/branch -> pc goes 0,4,8,12 every 2 cycles; instr equals the memory word at each pc.
3. Stalls:
   - imem_valid held low 3 cycles in FETCH -> imem_req stays 1, pc stable.
   - instr_ready low 4 cycles in ISSUE -> instr and pc stable, instr_valid=1 throughout.
4. Control flow:
   - pc=0x10, jump=1, offset=0xFE (-2) -> next pc=0x0C.
   - pc=0x10, branch=1, zero=0, offset=3 -> next pc=0x14.
   - pc=0x10, branch=1, zero=1, offset=3 -> next pc=0x20.
5. Wrap and mid-operation reset:
   - RESET_PC=0xFFFFFFFC, not taken -> next pc=0x00000000.
   - Reset asserted in ISSUE with instr_ready=1 -> no pc advance; pc=RESET_PC and instr_valid=0 after the edge.
6. FETCH_COUNT_EN defined: 5 retired instructions -> retired_count=5. Force the counter to 0xFFFF, retire one more -> stays 0xFFFF.
